// File: rtl/reg_transfer_ctrl.sv
// Register-bank transfer initiator: sequences bus read enables, captures the two
// read buses and drives write-back load strobes for READ/MOV/SWAP/ADD commands.
module reg_transfer_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int WIDTH    = 8,
  parameter int IDX_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [IDX_W-1:0]    cmd_rd,
  input  logic [IDX_W-1:0]    cmd_ra,
  input  logic [IDX_W-1:0]    cmd_rb,
  output logic [NUM_REGS-1:0] out0_en,
  output logic [NUM_REGS-1:0] out1_en,
  input  logic [WIDTH-1:0]    bus0,
  input  logic [WIDTH-1:0]    bus1,
  output logic [NUM_REGS-1:0] load,
  output logic [WIDTH-1:0]    wr_data,
  output logic                done,
  output logic [WIDTH-1:0]    result,
  output logic                carry,
  output logic                err
);

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_WB1, S_WB2, S_DONE} state_t;
  typedef enum logic [1:0] {OP_READ = 2'b00, OP_MOV = 2'b01, OP_SWAP = 2'b10, OP_ADD = 2'b11} op_t;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) v[i] = (32'(idx) == i);
    return v;
  endfunction

  function automatic logic idx_bad(input logic [IDX_W-1:0] idx);
    return 32'(idx) >= 32'(NUM_REGS);
  endfunction

  state_t               r_state, w_state;
  op_t                  r_op, w_op;
  logic [IDX_W-1:0]     r_rd, w_rd, r_ra, w_ra, r_rb, w_rb;
  logic [WIDTH-1:0]     r_opa, w_opa;
  logic                 r_carry_pend, w_carry_pend;
  logic                 r_cmd_ready, w_cmd_ready;
  logic [NUM_REGS-1:0]  r_out0_en, w_out0_en, r_out1_en, w_out1_en, r_load, w_load;
  logic [WIDTH-1:0]     r_wr_data, w_wr_data, r_result, w_result;
  logic                 r_done, w_done, r_carry, w_carry, r_err, w_err;
  logic [WIDTH:0]       w_sum;
  logic                 w_bad;
  op_t                  w_cmd_op;

  assign w_cmd_op = op_t'(cmd_op);
  assign w_sum    = {1'b0, bus0} + {1'b0, bus1};

  always_comb begin
    w_bad = idx_bad(cmd_ra);
    if (w_cmd_op != OP_MOV)                        w_bad = w_bad | idx_bad(cmd_rb);
    if (w_cmd_op == OP_MOV || w_cmd_op == OP_ADD) w_bad = w_bad | idx_bad(cmd_rd);
  end

  // Outputs are computed for the upcoming state and registered, so every strobe
  // is glitch-free and held for a full posedge-to-posedge cycle.
  always_comb begin
    w_state      = r_state;
    w_op         = r_op;
    w_rd         = r_rd;
    w_ra         = r_ra;
    w_rb         = r_rb;
    w_opa        = r_opa;
    w_carry_pend = r_carry_pend;
    w_cmd_ready  = 1'b0;
    w_out0_en    = '0;
    w_out1_en    = '0;
    w_load       = '0;
    w_wr_data    = '0;
    w_done       = 1'b0;
    w_result     = r_result;
    w_carry      = r_carry;
    w_err        = r_err;
    case (r_state)
      S_IDLE: begin
        w_cmd_ready = 1'b1;
        if (r_cmd_ready && cmd_valid) begin
          w_cmd_ready = 1'b0;
          w_op = w_cmd_op;
          w_rd = cmd_rd;
          w_ra = cmd_ra;
          w_rb = cmd_rb;
          if (w_bad) begin
            w_state  = S_DONE;
            w_done   = 1'b1;
            w_err    = 1'b1;
            w_result = '0;
            w_carry  = 1'b0;
          end else begin
            w_state   = S_DRIVE;
            w_out0_en = onehot(cmd_ra);
            if (w_cmd_op != OP_MOV) w_out1_en = onehot(cmd_rb);
          end
        end
      end
      S_DRIVE: begin
        w_opa        = bus0;
        w_carry_pend = w_sum[WIDTH];
        if (r_op == OP_READ) begin
          w_state  = S_DONE;
          w_done   = 1'b1;
          w_result = bus0;
          w_carry  = 1'b0;
          w_err    = 1'b0;
        end else begin
          w_state = S_WB1;
          case (r_op)
            OP_MOV:  begin w_load = onehot(r_rd); w_wr_data = bus0; end
            OP_ADD:  begin w_load = onehot(r_rd); w_wr_data = w_sum[WIDTH-1:0]; end
            default: begin w_load = onehot(r_ra); w_wr_data = bus1; end
          endcase
        end
      end
      S_WB1: begin
        if (r_op == OP_SWAP) begin
          w_state   = S_WB2;
          w_load    = onehot(r_rb);
          w_wr_data = r_opa;
        end else begin
          w_state  = S_DONE;
          w_done   = 1'b1;
          w_result = r_wr_data;
          w_carry  = (r_op == OP_ADD) ? r_carry_pend : 1'b0;
          w_err    = 1'b0;
        end
      end
      S_WB2: begin
        w_state  = S_DONE;
        w_done   = 1'b1;
        w_result = r_opa;
        w_carry  = 1'b0;
        w_err    = 1'b0;
      end
      S_DONE: begin
        w_state     = S_IDLE;
        w_cmd_ready = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= OP_READ;
      r_rd         <= '0;
      r_ra         <= '0;
      r_rb         <= '0;
      r_opa        <= '0;
      r_carry_pend <= 1'b0;
      r_cmd_ready  <= 1'b0;
      r_out0_en    <= '0;
      r_out1_en    <= '0;
      r_load       <= '0;
      r_wr_data    <= '0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_carry      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_op         <= w_op;
      r_rd         <= w_rd;
      r_ra         <= w_ra;
      r_rb         <= w_rb;
      r_opa        <= w_opa;
      r_carry_pend <= w_carry_pend;
      r_cmd_ready  <= w_cmd_ready;
      r_out0_en    <= w_out0_en;
      r_out1_en    <= w_out1_en;
      r_load       <= w_load;
      r_wr_data    <= w_wr_data;
      r_done       <= w_done;
      r_result     <= w_result;
      r_carry      <= w_carry;
      r_err        <= w_err;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign out0_en   = r_out0_en;
  assign out1_en   = r_out1_en;
  assign load      = r_load;
  assign wr_data   = r_wr_data;
  assign done      = r_done;
  assign result    = r_result;
  assign carry     = r_carry;
  assign err       = r_err;

endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// Directed bench for reg_transfer_ctrl with a behavioural 4-entry register bank
// that drives the read buses and loads on negedge.
module tb_reg_transfer_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cmd_valid = 1'b0, cmd_valid2 = 1'b0;
  logic [1:0] cmd_op = '0, cmd_rd = '0, cmd_ra = '0, cmd_rb = '0;
  logic       cmd_ready, done, carry, err;
  logic [3:0] out0_en, out1_en, load;
  logic [7:0] bus0, bus1, wr_data, result;

  logic       cmd_ready2, done2, carry2, err2;
  logic [2:0] out0_en2, out1_en2, load2;
  logic [7:0] wr_data2, result2;

  logic [7:0] regs [4];
  logic       tb_wr = 1'b0;
  logic [1:0] tb_idx = '0;
  logic [7:0] tb_val = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_transfer_ctrl #(.NUM_REGS(4), .WIDTH(8), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .out0_en(out0_en), .out1_en(out1_en), .bus0(bus0), .bus1(bus1),
    .load(load), .wr_data(wr_data), .done(done), .result(result),
    .carry(carry), .err(err)
  );

  reg_transfer_ctrl #(.NUM_REGS(3), .WIDTH(8), .IDX_W(2)) dut3 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb),
    .out0_en(out0_en2), .out1_en(out1_en2), .bus0(8'h5A), .bus1(8'h5A),
    .load(load2), .wr_data(wr_data2), .done(done2), .result(result2),
    .carry(carry2), .err(err2)
  );

  always_comb begin
    bus0 = 'z;
    bus1 = 'z;
    for (int i = 0; i < 4; i++) begin
      if (out0_en[i]) bus0 = regs[i];
      if (out1_en[i]) bus1 = regs[i];
    end
  end

  always @(negedge clk) begin
    if (tb_wr) regs[tb_idx] <= tb_val;
    for (int i = 0; i < 4; i++) if (load[i]) regs[i] <= wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [1:0] idx, input logic [7:0] val);
    tb_wr  = 1'b1;
    tb_idx = idx;
    tb_val = val;
    @(negedge clk);
    #1;
    tb_wr = 1'b0;
    tick();
  endtask

  // Leaves time at accept-edge + 1, i.e. inside the first post-accept cycle.
  task automatic issue(input logic [1:0] op, input logic [1:0] rd, input logic [1:0] ra,
                       input logic [1:0] rb);
    cmd_op = op; cmd_rd = rd; cmd_ra = ra; cmd_rb = rb;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_out0", out0_en, 0);
    chk("rst_out1", out1_en, 0);
    chk("rst_load", load, 0);
    chk("rst_wr", wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_carry_err", {carry, err}, 0);
    reset = 1'b0;
    tick();
    chk("ready_after_rst", cmd_ready, 1);

    poke(2'd1, 8'h3C);
    poke(2'd2, 8'hA5);
    poke(2'd0, 8'h7E);

    // READ ra=1 rb=2
    issue(2'b00, 2'd0, 2'd1, 2'd2);
    chk("rd_out0", out0_en, 4'b0010);
    chk("rd_out1", out1_en, 4'b0100);
    chk("rd_load_c1", load, 0);
    chk("rd_busy", {cmd_ready, done}, 0);
    tick();
    chk("rd_done", done, 1);
    chk("rd_result", result, 8'h3C);
    chk("rd_err", {carry, err}, 0);
    chk("rd_en_off", {out0_en, out1_en, load}, 0);
    tick();
    chk("rd_done_pulse", done, 0);
    chk("rd_ready", cmd_ready, 1);
    chk("rd_result_hold", result, 8'h3C);

    // MOV rd=3 ra=0
    issue(2'b01, 2'd3, 2'd0, 2'd2);
    chk("mov_out0", out0_en, 4'b0001);
    chk("mov_out1", out1_en, 0);
    tick();
    chk("mov_load", load, 4'b1000);
    chk("mov_wr", wr_data, 8'h7E);
    chk("mov_en_off", {out0_en, out1_en}, 0);
    chk("mov_not_done", done, 0);
    tick();
    chk("mov_done", done, 1);
    chk("mov_result", result, 8'h7E);
    chk("mov_load_off", load, 0);
    chk("mov_wr_off", wr_data, 0);
    chk("mov_r3", regs[3], 8'h7E);
    tick();

    // ADD rd=0 ra=0 rb=1 with carry
    poke(2'd0, 8'hF0);
    poke(2'd1, 8'h25);
    issue(2'b11, 2'd0, 2'd0, 2'd1);
    chk("add_out", {out0_en, out1_en}, 8'b0001_0010);
    tick();
    chk("add_load", load, 4'b0001);
    chk("add_wr", wr_data, 8'h15);
    tick();
    chk("add_done", done, 1);
    chk("add_result", result, 8'h15);
    chk("add_carry", carry, 1);
    chk("add_r0", regs[0], 8'h15);
    tick();

    // ADD without carry
    poke(2'd0, 8'h01);
    poke(2'd1, 8'h02);
    issue(2'b11, 2'd0, 2'd0, 2'd1);
    tick();
    chk("add2_wr", wr_data, 8'h03);
    tick();
    chk("add2_result", result, 8'h03);
    chk("add2_carry", carry, 0);
    chk("add2_r0", regs[0], 8'h03);
    tick();

    // SWAP ra=1 rb=2 with a cmd_valid pulse while busy
    poke(2'd1, 8'h11);
    poke(2'd2, 8'h22);
    issue(2'b10, 2'd0, 2'd1, 2'd2);
    chk("swp_out", {out0_en, out1_en}, 8'b0010_0100);
    cmd_op = 2'b00; cmd_ra = 2'd3; cmd_rb = 2'd3; cmd_valid = 1'b1;
    tick();
    chk("swp_load1", load, 4'b0010);
    chk("swp_wr1", wr_data, 8'h22);
    cmd_valid = 1'b0;
    tick();
    chk("swp_load2", load, 4'b0100);
    chk("swp_wr2", wr_data, 8'h11);
    chk("swp_not_done", done, 0);
    tick();
    chk("swp_done", done, 1);
    chk("swp_result", result, 8'h11);
    chk("swp_carry", carry, 0);
    chk("swp_regs", {regs[1], regs[2]}, 16'h2211);
    tick();
    chk("swp_ready", cmd_ready, 1);
    tick();
    chk("busy_ignored", {out0_en, out1_en, load, done}, 0);
    chk("busy_ignored_rdy", cmd_ready, 1);

    // Index out of range on a 3-register instance
    cmd_op = 2'b00; cmd_ra = 2'd3; cmd_rb = 2'd0;
    cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    chk("err_done", done2, 1);
    chk("err_flag", err2, 1);
    chk("err_no_strobes", {out0_en2, out1_en2, load2}, 0);
    tick();
    chk("err_done_pulse", done2, 0);
    chk("err_hold", err2, 1);
    chk("err_main_idle", done, 0);
    cmd_op = 2'b00; cmd_ra = 2'd2; cmd_rb = 2'd0;
    cmd_valid2 = 1'b1;
    tick();
    cmd_valid2 = 1'b0;
    chk("ok3_out", {out0_en2, out1_en2}, 6'b100_001);
    tick();
    chk("ok3_done", {done2, err2}, 2'b10);
    chk("ok3_result", result2, 8'h5A);
    tick();

    // Reset during WB1 of a SWAP
    poke(2'd1, 8'hAA);
    poke(2'd2, 8'hBB);
    issue(2'b10, 2'd0, 2'd1, 2'd2);
    tick();
    chk("abort_pre_load", load, 4'b0010);
    #1 reset = 1'b1;
    #1;
    chk("abort_load", load, 0);
    chk("abort_wr", wr_data, 0);
    chk("abort_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    chk("abort_ready", cmd_ready, 1);
    tick();
    chk("abort_quiet", {out0_en, out1_en, load, done}, 0);
    chk("abort_rb", regs[2], 8'hBB);
    chk("abort_ra", regs[1], 8'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_transfer_ctrl.md
Name: reg_transfer_ctrl

Overview:
- Bus-side initiator for the register bank: accepts one register-transfer command at a time and sequences the per-register out0_en/out1_en/load strobes.
- Captures operands from the two tri-state read buses and drives write-back data onto the register data_in bus.
- Sits between the instruction decoder and the register file; the registers are the responders that drive the buses and load on negedge.

Parameters:
- NUM_REGS, 4, number of registers on the buses (2..2**IDX_W).
- WIDTH, 8, data width of the buses and the registers.
- IDX_W, 2, width of register index fields.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  2  00 READ, 01 MOV, 10 SWAP, 11 ADD.
- cmd_rd  input  IDX_W  destination index (MOV/ADD).
- cmd_ra  input  IDX_W  source A, driven on bus0.
- cmd_rb  input  IDX_W  source B, driven on bus1.
- out0_en  output  NUM_REGS  one-hot read enable, bus0.
- out1_en  output  NUM_REGS  one-hot read enable, bus1.
- bus0  input  WIDTH  shared read bus 0.
- bus1  input  WIDTH  shared read bus 1.
- load  output  NUM_REGS  one-hot register load strobe.
- wr_data  output  WIDTH  write-back data to the registers' data_in.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  READ: bus0 value; MOV/ADD: written value; SWAP: old ra value.
- carry  output  1  ADD carry-out; 0 for other ops.
- err  output  1  index-range error, valid with done.

Behaviour:
- Reset (async, active-high):
  - state IDLE; all outputs 0 immediately, including out0_en, out1_en, load, wr_data, done, result, carry and err.
  - Reset mid-operation aborts the command: enables and loads drop at once and no partial write-back resumes.
- Output timing: all outputs are registered. Registers sample load on negedge, so each load/wr_data pair is held for one full posedge-to-posedge cycle.
- States: IDLE, DRIVE, WB1, WB2, DONE.
- IDLE:
  - cmd_ready=1.
  - On posedge with cmd_valid, latch op/rd/ra/rb.
  - If any used index >= NUM_REGS, go to DONE with err=1 and no strobes.
  - Otherwise go to DRIVE.
  - Used indices: READ ra, rb; MOV ra, rd; SWAP ra, rb; ADD ra, rb, rd.
- DRIVE:
  - out0_en[ra]=1; out1_en[rb]=1 for READ/SWAP/ADD only; MOV drives bus0 only.
  - At the closing posedge, capture opa=bus0 and opb=bus1.
  - Next state: READ goes to DONE; others go to WB1.
- WB1:
  - All enables 0.
  - MOV: load[rd]=1, wr_data=opa.
  - ADD: load[rd]=1, wr_data=(opa+opb) mod 2**WIDTH, carry=bit WIDTH of the sum.
  - SWAP: load[ra]=1, wr_data=opb.
  - Next state: SWAP goes to WB2, otherwise DONE.
- WB2 (SWAP only): load[rb]=1, wr_data=opa; go to DONE.
- DONE:
  - done=1, result/carry/err valid; loads and enables 0; go to IDLE.
  - result/carry/err hold until the next done.
- Latency, accept posedge to done-high cycle: READ 2 cycles, MOV/ADD 3, SWAP 4; error 1. Throughput is one command per (latency+1) cycles.
- Invariants:
  - At most one bit set in each of out0_en, out1_en and load.
  - load is never set in the same cycle as any out*_en.
  - wr_data returns to 0 when load is 0.
- Corner cases:
  - ra==rb is legal: both buses carry the same register; SWAP writes the same value twice.
  - rd equal to ra or rb is legal, since write-back follows capture.
  - cmd_valid while not ready is ignored; the command is not latched.
  - Bus contents during DRIVE are captured unchecked (Z/X propagate).

Test Plan:
- Reset, then READ ra=1, rb=2 with r1=0x3C, r2=0xA5 -> out0_en=0010 and out1_en=0100 for one cycle; done 2 cycles after accept; result=0x3C; no load pulse.
- MOV rd=3, ra=0 with r0=0x7E -> single load=1000 cycle with wr_data=0x7E; r3 reads 0x7E afterwards; done at cycle 3.
- ADD rd=0, ra=0, rb=1 with r0=0xF0, r1=0x25 -> wr_data=0x15, carry=1, r0=0x15 afterwards. Repeat with 0x01+0x02 -> 0x03, carry=0.
- SWAP ra=1, rb=2 (0x11, 0x22) -> load=0010/wr_data=0x22, then load=0100/wr_data=0x11; result=0x11; r1=0x22 and r2=0x11 afterwards; done at cycle 4.
- NUM_REGS=3, READ ra=3 -> done with err=1 one cycle after accept; no enables or loads asserted.
- Assert reset during WB1 of a SWAP -> load and wr_data go to 0 immediately; rb unchanged; cmd_ready=1 after reset release. A cmd_valid pulse while busy -> ignored.
